// File: rtl/hier_fanout_node.sv
// Command fan-out/aggregation node: broadcasts or unicasts one parent command to
// child slots, collects done/error pulses with an optional timeout, and returns one response.
module hier_fanout_node #(
    parameter int NUM_CHILDREN = 10,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT_W    = 16,
    parameter int SEL_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic [DATA_W-1:0]       up_data,
    input  logic                    up_mode,
    input  logic [SEL_W-1:0]        up_sel,
    input  logic [TIMEOUT_W-1:0]    timeout_cycles,
    output logic [NUM_CHILDREN-1:0] ch_valid,
    input  logic [NUM_CHILDREN-1:0] ch_ready,
    output logic [DATA_W-1:0]       ch_data,
    input  logic [NUM_CHILDREN-1:0] ch_done,
    input  logic [NUM_CHILDREN-1:0] ch_err,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [NUM_CHILDREN-1:0] rsp_done_mask,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CHILDREN-1:0] target_q, target_d;
    logic [NUM_CHILDREN-1:0] issued_q, issued_d;
    logic [NUM_CHILDREN-1:0] done_q, done_d;
    logic [NUM_CHILDREN-1:0] err_q, err_d;
    logic [TIMEOUT_W-1:0]    timer_q, timer_d;
    logic                    bad_sel_q, bad_sel_d;
    logic                    tmo_q, tmo_d;
    logic [DATA_W-1:0]       data_q, data_d;

    logic                    sel_oob;
    logic                    timeout_hit;
    logic                    in_resp;
    logic [NUM_CHILDREN-1:0] offer;
    logic [NUM_CHILDREN-1:0] done_upd;

    // Every handshake (up, ch[i], rsp) transfers on a rising edge where valid and ready
    // are both high; valid never depends combinationally on the matching ready.
    assign sel_oob     = 32'(up_sel) >= 32'(NUM_CHILDREN);
    assign offer       = (state_q == S_ISSUE) ? (target_q & ~issued_q) : '0;
    assign done_upd    = done_q | (ch_done & issued_q);
    assign timeout_hit = (timeout_cycles != '0) &&
                         (timer_q == timeout_cycles - TIMEOUT_W'(1));

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        issued_d  = issued_q;
        done_d    = done_q;
        err_d     = err_q;
        timer_d   = timer_q;
        bad_sel_d = bad_sel_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        case (state_q)
            S_IDLE: begin
                if (up_valid) begin
                    data_d    = up_data;
                    bad_sel_d = up_mode && sel_oob;
                    if (!up_mode)
                        target_d = '1;
                    else if (sel_oob)
                        target_d = '0;
                    else
                        target_d = NUM_CHILDREN'(1) << up_sel;
                    issued_d  = '0;
                    done_d    = '0;
                    err_d     = '0;
                    timer_d   = '0;
                    tmo_d     = 1'b0;
                    state_d   = (up_mode && sel_oob) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                // A done only counts once the child's issue was registered.
                issued_d = issued_q | (offer & ch_ready);
                done_d   = done_upd;
                err_d    = err_q | (ch_done & ch_err & issued_q);
                timer_d  = timer_q + TIMEOUT_W'(1);
                if (done_upd == target_q) begin
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    state_d = S_RESP;
                    tmo_d   = 1'b1;
                end else if (state_q == S_ISSUE && issued_d == target_q) begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            issued_q  <= '0;
            done_q    <= '0;
            err_q     <= '0;
            timer_q   <= '0;
            bad_sel_q <= 1'b0;
            tmo_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            issued_q  <= issued_d;
            done_q    <= done_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            bad_sel_q <= bad_sel_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
        end
    end

    assign in_resp       = (state_q == S_RESP);
    assign up_ready      = (state_q == S_IDLE);
    assign ch_valid      = offer;
    assign ch_data       = data_q;
    assign rsp_valid     = in_resp;
    assign rsp_err       = in_resp & ((|err_q) | bad_sel_q | tmo_q);
    assign rsp_timeout   = in_resp & tmo_q;
    assign rsp_done_mask = in_resp ? done_q : '0;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_hier_fanout_node.sv
// Bench for hier_fanout_node: directed scenarios with literal expectations plus random
// traffic, all outputs compared every cycle against a transaction-level model.
module tb_hier_fanout_node;
    localparam int NC = 10;
    localparam int DW = 32;
    localparam int TW = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [DW-1:0] up_data = '0;
    logic          up_mode = 1'b0;
    logic [SW-1:0] up_sel = '0;
    logic [TW-1:0] timeout_cycles = '0;
    logic [NC-1:0] ch_valid;
    logic [NC-1:0] ch_ready = '0;
    logic [DW-1:0] ch_data;
    logic [NC-1:0] ch_done = '0;
    logic [NC-1:0] ch_err = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [NC-1:0] rsp_done_mask;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rand_en = 1'b0;

    hier_fanout_node #(.NUM_CHILDREN(NC), .DATA_W(DW), .TIMEOUT_W(TW), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
        .up_mode(up_mode), .up_sel(up_sel), .timeout_cycles(timeout_cycles),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
        .ch_done(ch_done), .ch_err(ch_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .rsp_done_mask(rsp_done_mask),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one outstanding command, per-child sets, elapsed age.
    logic          m_busy = 1'b0, m_resp = 1'b0, m_bad = 1'b0, m_tmo = 1'b0;
    logic [NC-1:0] m_target = '0, m_issued = '0, m_done = '0, m_err = '0, m_offered;
    logic [DW-1:0] m_data = '0;
    int            m_age = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 0; m_resp = 0; m_bad = 0; m_tmo = 0;
            m_target = '0; m_issued = '0; m_done = '0; m_err = '0;
            m_data = '0; m_age = 0;
        end else if (!m_busy) begin
            if (up_valid) begin
                m_busy = 1; m_data = up_data; m_age = 0; m_tmo = 0;
                m_issued = '0; m_done = '0; m_err = '0;
                m_bad = up_mode && (int'(up_sel) >= NC);
                if (!up_mode) m_target = '1;
                else if (m_bad) m_target = '0;
                else begin
                    m_target = '0;
                    m_target[up_sel] = 1'b1;
                end
                m_resp = m_bad;
            end
        end else if (m_resp) begin
            if (rsp_ready) begin
                m_busy = 0; m_resp = 0;
            end
        end else begin
            m_offered = m_target & ~m_issued;
            m_done    = m_done | (ch_done & m_issued);
            m_err     = m_err | (ch_done & ch_err & m_issued);
            m_issued  = m_issued | (m_offered & ch_ready);
            m_age++;
            if (m_done == m_target) m_resp = 1;
            else if (timeout_cycles != 0 && m_age == int'(timeout_cycles)) begin
                m_resp = 1; m_tmo = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("up_ready", up_ready, !m_busy);
        check("ch_valid", ch_valid, (m_busy && !m_resp) ? (m_target & ~m_issued) : '0);
        check("ch_data", ch_data, m_data);
        check("rsp_valid", rsp_valid, m_resp);
        if (m_resp) begin
            check("rsp_err", rsp_err, (|m_err) | m_bad | m_tmo);
            check("rsp_timeout", rsp_timeout, m_tmo);
            check("rsp_done_mask", rsp_done_mask, m_done);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rand_en) begin
            ch_ready  = NC'($urandom);
            ch_done   = NC'($urandom & $urandom);
            ch_err    = NC'($urandom);
            rsp_ready = ($urandom_range(0, 2) == 0);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (up_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (up_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle: up_ready=%b required 1 within 300 cycles", up_ready);
        end
    endtask

    // Returns mid-cycle N+1 when the command was accepted at cycle N.
    task automatic send(input logic mode, input logic [SW-1:0] sel,
                        input logic [DW-1:0] d, input logic [TW-1:0] t);
        wait_idle();
        up_valid = 1'b1; up_mode = mode; up_sel = sel; up_data = d; timeout_cycles = t;
        @(negedge clk);
        up_valid = 1'b0; up_data = $urandom;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic t_bcast(input logic [DW-1:0] d);
        send(1'b0, '0, d, '0);
        check("bc_ch_valid_n1", ch_valid, 64'h3FF);
        check("bc_ch_data", ch_data, d);
        ch_ready = '1;
        @(negedge clk);
        ch_ready = '0; ch_done = '1; ch_err = NC'(1 << 3);
        check("bc_rsp_valid_n2", rsp_valid, 0);
        @(negedge clk);
        ch_done = '0; ch_err = '0;
        check("bc_rsp_valid_n3", rsp_valid, 1);
        check("bc_mask", rsp_done_mask, 64'h3FF);
        check("bc_err", rsp_err, 1);
        check("bc_timeout", rsp_timeout, 0);
        check("bc_up_ready_busy", up_ready, 0);
        ack();
        check("bc_up_ready_after", up_ready, 1);
    endtask

    task automatic t_unicast7();
        logic [NC-1:0] ever;
        ever = '0;
        send(1'b1, 4'd7, 32'hA5A5_0007, '0);
        for (int k = 1; k <= 10; k++) begin
            ever |= ch_valid;
            check("uc_no_rsp", rsp_valid, 0);
            ch_ready = (k == 5) ? '1 : '0;
            ch_done  = (k == 3 || k == 7) ? NC'(1 << 2) : ((k == 10) ? NC'(1 << 7) : '0);
            ch_err   = (k == 3 || k == 7) ? '1 : '0;
            @(negedge clk);
        end
        ch_done = '0; ch_err = '0; ch_ready = '0;
        check("uc_rsp_valid", rsp_valid, 1);
        check("uc_ever_valid", ever, 64'h080);
        check("uc_mask", rsp_done_mask, 64'h080);
        check("uc_err", rsp_err, 0);
        check("uc_timeout", rsp_timeout, 0);
        ack();
    endtask

    task automatic t_badsel();
        send(1'b1, 4'd12, 32'hBAD0_000C, '0);
        check("bs_rsp_valid", rsp_valid, 1);
        check("bs_ch_valid", ch_valid, 0);
        check("bs_err", rsp_err, 1);
        check("bs_mask", rsp_done_mask, 0);
        check("bs_timeout", rsp_timeout, 0);
        ack();
    endtask

    task automatic t_timeout();
        int early;
        send(1'b0, '0, 32'h7100_0020, 16'd20);
        for (int k = 1; k <= 20; k++) begin
            check("to_no_rsp", rsp_valid, 0);
            ch_ready = (k == 1) ? '1 : '0;
            ch_done  = (k == 2) ? NC'('h1FF) : '0;
            @(negedge clk);
        end
        check("to_rsp_valid_n21", rsp_valid, 1);
        check("to_timeout", rsp_timeout, 1);
        check("to_mask", rsp_done_mask, 64'h1FF);
        check("to_err", rsp_err, 1);
        ack();
        early = 0;
        send(1'b0, '0, 32'h7100_0000, '0);
        for (int k = 1; k <= 45; k++) begin
            if (rsp_valid !== 1'b0) early++;
            ch_ready = (k == 1) ? '1 : '0;
            ch_done  = (k == 2) ? NC'('h1FF) : ((k == 45) ? NC'(1 << 9) : '0);
            @(negedge clk);
        end
        ch_done = '0;
        check("t0_no_early_rsp", early, 0);
        check("t0_rsp_valid", rsp_valid, 1);
        check("t0_mask", rsp_done_mask, 64'h3FF);
        check("t0_timeout", rsp_timeout, 0);
        check("t0_err", rsp_err, 0);
        ack();
    endtask

    task automatic t_hold();
        send(1'b0, '0, 32'h0000_D0D0, '0);
        ch_ready = '1; ch_done = NC'(1);
        @(negedge clk);
        ch_ready = '0; ch_done = NC'('h3FE);
        @(negedge clk);
        ch_done = NC'(1);
        check("hd_rsp_valid_n3", rsp_valid, 0);
        @(negedge clk);
        ch_done = '0;
        for (int k = 0; k < 5; k++) begin
            check("hd_rsp_valid", rsp_valid, 1);
            check("hd_mask", rsp_done_mask, 64'h3FF);
            check("hd_err", rsp_err, 0);
            check("hd_timeout", rsp_timeout, 0);
            check("hd_up_ready", up_ready, 0);
            @(negedge clk);
        end
        check("hd_up_ready_hs", up_ready, 0);
        ack();
        check("hd_up_ready_after", up_ready, 1);
    endtask

    task automatic t_reset();
        send(1'b0, '0, 32'h5EE5_0001, '0);
        ch_ready = '1;
        @(negedge clk);
        ch_ready = '0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rw_ch_valid", ch_valid, 0);
        check("rw_rsp_valid", rsp_valid, 0);
        check("rw_up_ready", up_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, '0, 32'h5EE5_0002, '0);
        check("ri_ch_valid_before", ch_valid, 64'h3FF);
        #2 rst_n = 1'b0;
        #1;
        check("ri_ch_valid", ch_valid, 0);
        check("ri_up_ready", up_ready, 1);
        check("ri_ch_data", ch_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_up_ready", up_ready, 1);
        check("rst_ch_valid", ch_valid, 0);
        check("rst_ch_data", ch_data, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_mask", rsp_done_mask, 0);
        rst_n = 1'b1;
        @(negedge clk);
        t_bcast(32'hCAFE_0001);
        t_unicast7();
        t_badsel();
        t_timeout();
        t_hold();
        t_reset();
        t_bcast(32'h1234_5678);
        rand_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic          md;
            logic [SW-1:0] sl;
            logic [TW-1:0] tc;
            md = ($urandom_range(0, 9) < 4);
            sl = SW'($urandom_range(0, 15));
            tc = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(1, 30));
            send(md, sl, $urandom, tc);
        end
        wait_idle();
        rand_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
